hex_keypad_event_unit: RTL and testbench

- Parametrised successor to the current keyboard/button front end.
- Takes the byte stream from PS2Keyboard (data/valid_data) and parses make, break and extended prefixes. Hex-key make events are queued in a FIFO with a valid/ready pop interface.
- Also debounces NUM_BUTTONS push-buttons with level outputs and press pulses.
- Sits between PS2Keyboard/board keys and the central unit's operand-entry logic.

---
 rtl/hex_keypad_event_unit.sv | 213 +++++++++++++++++++++
 tb/tb_hex_keypad_event_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_event_unit.sv
// PS/2 hex-key event queue plus debounced push-buttons.
// Define TYPEMATIC_EN to queue repeat makes of an already-held hex key.
module hex_keypad_event_unit #(
    parameter int FIFO_DEPTH      = 8,
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    scan_code,
    input  logic                          scan_valid,
    input  logic                          key_ready,
    input  logic                          clear_overflow,
    input  logic [NUM_BUTTONS-1:0]        buttons_raw,
    output logic [3:0]                    key_data,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   key_count,
    output logic                          overflow,
    output logic [15:0]                   held_mask,
    output logic [NUM_BUTTONS-1:0]        buttons_level,
    output logic [NUM_BUTTONS-1:0]        buttons_pressed
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_e;

    state_e state_q, state_d;

    logic        is_hex;
    logic [3:0]  hex_val;
    logic        make_hit;
    logic        break_hit;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        full;

    logic [15:0]   held_q, held_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] level_q, level_d;
    logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
    logic [DW-1:0]          cnt_q [NUM_BUTTONS];
    logic [DW-1:0]          cnt_d [NUM_BUTTONS];

    always_comb begin
        is_hex  = 1'b1;
        hex_val = 4'h0;
        case (scan_code)
            8'h45:   hex_val = 4'h0;
            8'h16:   hex_val = 4'h1;
            8'h1E:   hex_val = 4'h2;
            8'h26:   hex_val = 4'h3;
            8'h25:   hex_val = 4'h4;
            8'h2E:   hex_val = 4'h5;
            8'h36:   hex_val = 4'h6;
            8'h3D:   hex_val = 4'h7;
            8'h3E:   hex_val = 4'h8;
            8'h46:   hex_val = 4'h9;
            8'h1C:   hex_val = 4'hA;
            8'h32:   hex_val = 4'hB;
            8'h21:   hex_val = 4'hC;
            8'h23:   hex_val = 4'hD;
            8'h24:   hex_val = 4'hE;
            8'h2B:   hex_val = 4'hF;
            default: is_hex  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        make_hit  = 1'b0;
        break_hit = 1'b0;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_BREAK;
                    end else if (scan_code == 8'hE0) begin
                        state_d = S_EXT;
                    end else begin
                        make_hit = is_hex;
                    end
                end
                S_BREAK: begin
                    break_hit = is_hex;
                    state_d   = S_IDLE;
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BREAK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        held_d = held_q;
        if (make_hit) held_d[hex_val] = 1'b1;
        if (break_hit) held_d[hex_val] = 1'b0;
    end

`ifdef TYPEMATIC_EN
    assign push_req = make_hit;
`else
    assign push_req = make_hit & ~held_q[hex_val];
`endif

    // a pop frees the head slot, so a push into a full FIFO still lands
    assign key_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = key_valid & key_ready;
    assign push      = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (clear_overflow) ovf_d = 1'b0;
        if (push_req && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            held_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= hex_val;
        end
    end

    assign key_data  = mem_q[rd_ptr_q];
    assign key_count = count_q;
    assign overflow  = ovf_q;
    assign held_mask = held_q;

    always_comb begin
        level_d   = level_q;
        pressed_d = '0;
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    level_d[b]   = sync2_q[b];
                    pressed_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            pressed_q <= '0;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            sync1_q   <= buttons_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            pressed_q <= pressed_d;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign buttons_level   = level_q;
    assign buttons_pressed = pressed_q;

endmodule

// File: tb/tb_hex_keypad_event_unit.sv
// Directed bench for hex_keypad_event_unit.
// Expected values are hand-derived; TYPEMATIC_EN selects the repeat case.
module tb_hex_keypad_event_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        key_ready;
    logic        clear_overflow;
    logic [3:0]  buttons_raw;
    logic [3:0]  key_data;
    logic        key_valid;
    logic [3:0]  key_count;
    logic        overflow;
    logic [15:0] held_mask;
    logic [3:0]  buttons_level;
    logic [3:0]  buttons_pressed;

    int errors = 0;
    int checks = 0;
    int pulses;
    int bad;
    logic prev_lvl;

    hex_keypad_event_unit #(
        .FIFO_DEPTH(8),
        .NUM_BUTTONS(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .scan_code(scan_code),
        .scan_valid(scan_valid),
        .key_ready(key_ready),
        .clear_overflow(clear_overflow),
        .buttons_raw(buttons_raw),
        .key_data(key_data),
        .key_valid(key_valid),
        .key_count(key_count),
        .overflow(overflow),
        .held_mask(held_mask),
        .buttons_level(buttons_level),
        .buttons_pressed(buttons_pressed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic tap(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        scan_code      = 8'h00;
        scan_valid     = 1'b0;
        key_ready      = 1'b0;
        clear_overflow = 1'b0;
        buttons_raw    = '0;
        repeat (3) tick();

        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_data", 32'(key_data), 0);
        chk("rst_count", 32'(key_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_held", 32'(held_mask), 0);
        chk("rst_level", 32'(buttons_level), 0);
        chk("rst_press", 32'(buttons_pressed), 0);
        reset = 1'b1;
        tick();

        send(8'h16);
        chk("mk1_valid", 32'(key_valid), 1);
        chk("mk1_data", 32'(key_data), 1);
        chk("mk1_count", 32'(key_count), 1);
        chk("mk1_held", 32'(held_mask), 32'h0002);
        key_ready = 1'b1;
        tick();
        tick();
        key_ready = 1'b0;
        chk("pop1_valid", 32'(key_valid), 0);
        chk("pop1_count", 32'(key_count), 0);
        send(8'hF0);
        send(8'h16);
        chk("brk1_held", 32'(held_mask), 0);

        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hE0);
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        chk("seq_count", 32'(key_count), 1);
        chk("seq_data", 32'(key_data), 32'hA);
        chk("seq_held", 32'(held_mask), 0);
        send(8'h45);
        chk("seq_idle_count", 32'(key_count), 2);
        chk("seq_idle_held", 32'(held_mask), 32'h0001);
        pop_one();
        chk("seq_pop_data", 32'(key_data), 0);
        pop_one();
        chk("seq_empty", 32'(key_valid), 0);
        send(8'hF0);
        send(8'h45);

        send(8'h26);
        send(8'h26);
        send(8'h26);
`ifdef TYPEMATIC_EN
        chk("rep_count", 32'(key_count), 3);
        for (int i = 0; i < 3; i++) begin
            chk("rep_data", 32'(key_data), 3);
            pop_one();
        end
`else
        chk("rep_count", 32'(key_count), 1);
        chk("rep_data", 32'(key_data), 3);
        pop_one();
`endif
        chk("rep_empty", 32'(key_valid), 0);
        send(8'hF0);
        send(8'h26);
        chk("rep_held", 32'(held_mask), 0);

        tap(8'h16);
        tap(8'h1E);
        tap(8'h26);
        tap(8'h25);
        tap(8'h2E);
        tap(8'h36);
        tap(8'h3D);
        tap(8'h3E);
        chk("full_ovf_pre", 32'(overflow), 0);
        tap(8'h46);
        chk("full_count", 32'(key_count), 8);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_head", 32'(key_data), 1);

        key_ready = 1'b1;
        send(8'h1C);
        key_ready = 1'b0;
        chk("fpp_count", 32'(key_count), 8);
        chk("fpp_ovf", 32'(overflow), 1);
        chk("fpp_head", 32'(key_data), 2);
        send(8'hF0);
        send(8'h1C);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);

        clear_overflow = 1'b1;
        send(8'h1C);
        clear_overflow = 1'b0;
        chk("set_beats_clr", 32'(overflow), 1);
        chk("drop_count", 32'(key_count), 8);
        send(8'hF0);
        send(8'h1C);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;

        chk("drain_d0", 32'(key_data), 2);
        pop_one();
        chk("drain_d1", 32'(key_data), 3);
        pop_one();
        chk("drain_d2", 32'(key_data), 4);
        pop_one();
        chk("drain_d3", 32'(key_data), 5);
        pop_one();
        chk("drain_d4", 32'(key_data), 6);
        pop_one();
        chk("drain_d5", 32'(key_data), 7);
        pop_one();
        chk("drain_d6", 32'(key_data), 8);
        pop_one();
        chk("drain_d7", 32'(key_data), 32'hA);
        pop_one();
        chk("drain_empty", 32'(key_valid), 0);
        chk("drain_count", 32'(key_count), 0);
        chk("drain_ovf", 32'(overflow), 0);

        bad = 0;
        for (int i = 0; i < 12; i++) begin
            buttons_raw[2] = (i % 2 == 0);
            tick();
            if (buttons_level[2] || buttons_pressed[2]) bad++;
        end
        buttons_raw[2] = 1'b0;
        repeat (4) tick();
        chk("bounce_events", 32'(bad), 0);
        chk("bounce_level", 32'(buttons_level), 0);

        pulses = 0;
        bad = 0;
        prev_lvl = buttons_level[2];
        buttons_raw[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (buttons_pressed[2]) pulses++;
            if (buttons_pressed[2] != (buttons_level[2] && !prev_lvl)) bad++;
            prev_lvl = buttons_level[2];
        end
        chk("press_level", 32'(buttons_level), 32'h4);
        chk("press_pulses", 32'(pulses), 1);
        chk("press_align", 32'(bad), 0);

        pulses = 0;
        buttons_raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (buttons_pressed != '0) pulses++;
        end
        chk("rel_level", 32'(buttons_level), 0);
        chk("rel_pulses", 32'(pulses), 0);

        tap(8'h16);
        tap(8'h1E);
        tap(8'h26);
        tap(8'h25);
        send(8'h2E);
        send(8'hF0);
        chk("pre_rst_count", 32'(key_count), 5);
        chk("pre_rst_held", 32'(held_mask), 32'h0020);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(key_valid), 0);
        chk("arst_count", 32'(key_count), 0);
        chk("arst_data", 32'(key_data), 0);
        chk("arst_held", 32'(held_mask), 0);
        chk("arst_ovf", 32'(overflow), 0);
        tick();
        reset = 1'b1;
        tick();
        send(8'h45);
        chk("post_rst_valid", 32'(key_valid), 1);
        chk("post_rst_count", 32'(key_count), 1);
        chk("post_rst_data", 32'(key_data), 0);
        chk("post_rst_held", 32'(held_mask), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
